// File: rtl/sdram_init_checker.sv
// Passive checker for the SDRAM power-up command sequence.
// Tracks NOP window, PALL, refreshes and LOAD MODE; flags the first violation.
module sdram_init_checker #(
    parameter int T_PWR       = 10000,
    parameter int MIN_REFRESH = 2,
    parameter int T_RP        = 1,
    parameter int T_RFC       = 2,
    parameter int T_MRD       = 2
) (
    input  logic        iclk,
    input  logic        ireset,
    input  logic        DRAM_CKE,
    input  logic        DRAM_CS_N,
    input  logic        DRAM_RAS_N,
    input  logic        DRAM_CAS_N,
    input  logic        DRAM_WE_N,
    input  logic [12:0] DRAM_ADDR,
    input  logic [1:0]  DRAM_BA,
    output logic        odone,
    output logic        oerr,
    output logic [2:0]  oerr_code,
    output logic [12:0] omode,
    output logic [3:0]  oburst_len,
    output logic [1:0]  ocas_lat,
    output logic [7:0]  oref_count
);

    typedef enum logic [2:0] {
        S_PWR,
        S_PRE,
        S_REF,
        S_MRD,
        S_RDY,
        S_ERR
    } state_t;

    localparam logic [15:0] L_PWR = 16'(T_PWR);
    localparam logic [7:0]  L_MIN = 8'(MIN_REFRESH);
    localparam logic [7:0]  L_RP  = 8'(T_RP);
    localparam logic [7:0]  L_RFC = 8'(T_RFC);
    localparam logic [7:0]  L_MRD = 8'(T_MRD);

    state_t      r_state;
    logic [15:0] r_pwr;
    logic [7:0]  r_gap;
    logic [7:0]  r_ref;
    logic        r_last_ref;
    logic        r_done;
    logic        r_err;
    logic [2:0]  r_code;
    logic [12:0] r_mode;
    logic [3:0]  r_bl;
    logic [1:0]  r_cl;

    state_t      w_state_n;
    logic [15:0] w_pwr_n;
    logic [15:0] w_pwr_inc;
    logic [7:0]  w_gap_n;
    logic [7:0]  w_gap;
    logic [7:0]  w_ref_n;
    logic        w_last_ref_n;
    logic [2:0]  w_code_n;
    logic [12:0] w_mode_n;
    logic [3:0]  w_bl_n;
    logic [1:0]  w_cl_n;
    logic [2:0]  w_viol;
    logic        w_acc;

    logic [3:0]  w_cmd;
    logic        w_nop;
    logic        w_pre;
    logic        w_rfs;
    logic        w_lmr;
    logic        w_ill;
    logic [3:0]  w_bl;
    logic        w_bl_ok;
    logic [1:0]  w_cl;
    logic        w_cl_ok;
    logic        w_unused_ba;

    assign w_unused_ba = ^DRAM_BA;

    assign w_cmd = {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N};
    assign w_nop = DRAM_CS_N || (w_cmd == 4'b0111);
    assign w_pre = (w_cmd == 4'b0010);
    assign w_rfs = (w_cmd == 4'b0001);
    assign w_lmr = (w_cmd == 4'b0000);
    assign w_ill = !(w_nop || w_pre || w_rfs || w_lmr);

    // gap as seen on this edge: cycles since the last accepted command
    assign w_gap     = (r_gap == 8'hFF) ? 8'hFF : r_gap + 8'd1;
    assign w_pwr_inc = (r_pwr == 16'hFFFF) ? 16'hFFFF : r_pwr + 16'd1;

    always_comb begin
        w_bl    = 4'd0;
        w_bl_ok = 1'b1;
        case (DRAM_ADDR[2:0])
            3'b000:  w_bl = 4'd1;
            3'b001:  w_bl = 4'd2;
            3'b010:  w_bl = 4'd4;
            3'b011:  w_bl = 4'd8;
            3'b111:  w_bl = 4'd0;
            default: w_bl_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_cl    = 2'd0;
        w_cl_ok = 1'b1;
        case (DRAM_ADDR[6:4])
            3'b010:  w_cl = 2'd2;
            3'b011:  w_cl = 2'd3;
            default: w_cl_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_state_n    = r_state;
        w_pwr_n      = r_pwr;
        w_gap_n      = r_gap;
        w_ref_n      = r_ref;
        w_last_ref_n = r_last_ref;
        w_code_n     = r_code;
        w_mode_n     = r_mode;
        w_bl_n       = r_bl;
        w_cl_n       = r_cl;
        w_viol       = 3'd0;
        w_acc        = 1'b0;
        if (DRAM_CKE) begin
            case (r_state)
                S_PWR: begin
                    if (!w_nop) begin
                        w_viol = 3'd1;
                    end else begin
                        w_pwr_n = w_pwr_inc;
                        if (w_pwr_inc >= L_PWR) w_state_n = S_PRE;
                    end
                end
                S_PRE: begin
                    if (w_pre) begin
                        if (!DRAM_ADDR[10]) begin
                            w_viol = 3'd2;
                        end else if (w_gap >= 8'd1) begin
                            w_state_n    = S_REF;
                            w_ref_n      = 8'd0;
                            w_last_ref_n = 1'b0;
                            w_acc        = 1'b1;
                        end
                    end else if (w_rfs || w_lmr) begin
                        w_viol = 3'd3;
                    end else if (w_ill) begin
                        w_viol = 3'd5;
                    end
                end
                S_REF: begin
                    if (w_rfs) begin
                        if (w_gap < (r_last_ref ? L_RFC : L_RP)) begin
                            w_viol = 3'd4;
                        end else begin
                            w_ref_n = (r_ref == 8'hFF) ? 8'hFF
                                                       : r_ref + 8'd1;
                            w_last_ref_n = 1'b1;
                            w_acc        = 1'b1;
                        end
                    end else if (w_lmr) begin
                        if (r_ref < L_MIN) begin
                            w_viol = 3'd3;
                        end else if (w_gap < L_RFC) begin
                            w_viol = 3'd4;
                        end else begin
                            w_mode_n = DRAM_ADDR;
                            if (!w_bl_ok || !w_cl_ok) begin
                                w_viol = 3'd7;
                            end else begin
                                w_bl_n    = w_bl;
                                w_cl_n    = w_cl;
                                w_state_n = S_MRD;
                                w_acc     = 1'b1;
                            end
                        end
                    end else if (w_pre) begin
                        w_viol = 3'd3;
                    end else if (w_ill) begin
                        w_viol = 3'd5;
                    end
                end
                S_MRD: begin
                    if (!w_nop) begin
                        w_viol = 3'd6;
                    end else if (w_gap == L_MRD) begin
                        w_state_n = S_RDY;
                    end
                end
                default: ;
            endcase
            w_gap_n = w_acc ? 8'd0 : w_gap;
            if (w_viol != 3'd0) begin
                w_state_n = S_ERR;
                w_code_n  = w_viol;
            end
        end
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            r_state    <= S_PWR;
            r_pwr      <= 16'd0;
            r_gap      <= 8'd0;
            r_ref      <= 8'd0;
            r_last_ref <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_code     <= 3'd0;
            r_mode     <= 13'd0;
            r_bl       <= 4'd0;
            r_cl       <= 2'd0;
        end else begin
            r_state    <= w_state_n;
            r_pwr      <= w_pwr_n;
            r_gap      <= w_gap_n;
            r_ref      <= w_ref_n;
            r_last_ref <= w_last_ref_n;
            r_done     <= (w_state_n == S_RDY);
            r_err      <= (w_state_n == S_ERR);
            r_code     <= w_code_n;
            r_mode     <= w_mode_n;
            r_bl       <= w_bl_n;
            r_cl       <= w_cl_n;
        end
    end

    assign odone      = r_done;
    assign oerr       = r_err;
    assign oerr_code  = r_code;
    assign omode      = r_mode;
    assign oburst_len = r_bl;
    assign ocas_lat   = r_cl;
    assign oref_count = r_ref;

endmodule

// File: tb/tb_sdram_init_checker.sv
// Bench for sdram_init_checker: full-size instance for the power-up window,
// short-window instance for tables, corner sequences and random traffic.
module tb_sdram_init_checker;

    localparam int FP = 8;

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_DES = 4'b1111;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_MRS = 4'b0000;
    localparam logic [3:0] C_ACT = 4'b0011;

    localparam int P_PWR = 0;
    localparam int P_PRE = 1;
    localparam int P_REF = 2;
    localparam int P_MRD = 3;
    localparam int P_RDY = 4;
    localparam int P_ERR = 5;

    logic        iclk = 1'b0;
    logic        rst_s = 1'b1;
    logic        rst_f = 1'b1;
    logic        cke = 1'b1;
    logic [3:0]  cmd = C_NOP;
    logic [12:0] addr = 13'd0;
    logic [1:0]  ba = 2'd0;

    logic        s_done, s_err, f_done, f_err;
    logic [2:0]  s_code, f_code;
    logic [12:0] s_mode, f_mode;
    logic [3:0]  s_bl, f_bl;
    logic [1:0]  s_cl, f_cl;
    logic [7:0]  s_refc, f_refc;

    always #5 iclk = ~iclk;

    sdram_init_checker u_slow (
        .iclk(iclk), .ireset(rst_s), .DRAM_CKE(cke),
        .DRAM_CS_N(cmd[3]), .DRAM_RAS_N(cmd[2]),
        .DRAM_CAS_N(cmd[1]), .DRAM_WE_N(cmd[0]),
        .DRAM_ADDR(addr), .DRAM_BA(ba),
        .odone(s_done), .oerr(s_err), .oerr_code(s_code),
        .omode(s_mode), .oburst_len(s_bl), .ocas_lat(s_cl),
        .oref_count(s_refc)
    );

    sdram_init_checker #(.T_PWR(FP)) u_fast (
        .iclk(iclk), .ireset(rst_f), .DRAM_CKE(cke),
        .DRAM_CS_N(cmd[3]), .DRAM_RAS_N(cmd[2]),
        .DRAM_CAS_N(cmd[1]), .DRAM_WE_N(cmd[0]),
        .DRAM_ADDR(addr), .DRAM_BA(ba),
        .odone(f_done), .oerr(f_err), .oerr_code(f_code),
        .omode(f_mode), .oburst_len(f_bl), .ocas_lat(f_cl),
        .oref_count(f_refc)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // reference model: phases plus timestamps of sampled cycles
    int          m_ph, m_t, m_last, m_pwr, m_refs, m_code, m_bl, m_cl;
    bit          m_lastref;
    logic [12:0] m_mode;

    function automatic int bl_of(input logic [2:0] f);
        if (f < 3'd4) return 1 << f;
        if (f == 3'd7) return 0;
        return -1;
    endfunction

    function automatic int cl_of(input logic [2:0] f);
        if (f == 3'd2 || f == 3'd3) return int'(f);
        return -1;
    endfunction

    task automatic model_reset();
        m_ph = P_PWR; m_t = 0; m_last = 0; m_pwr = 0; m_refs = 0;
        m_code = 0; m_bl = 0; m_cl = 0; m_lastref = 0; m_mode = 0;
    endtask

    task automatic model_step(input logic k, input logic [3:0] c,
                              input logic [12:0] a);
        int  g, v, b, l;
        bit  nop, is_pre, is_ref, is_mrs;
        if (!k) return;
        m_t++;
        g = m_t - m_last;
        if (g > 255) g = 255;
        nop    = c[3] || c == C_NOP;
        is_pre = (c == C_PRE);
        is_ref = (c == C_REF);
        is_mrs = (c == C_MRS);
        v = 0;
        case (m_ph)
            P_PWR: begin
                if (!nop) v = 1;
                else begin
                    if (m_pwr < 65535) m_pwr++;
                    if (m_pwr >= FP) m_ph = P_PRE;
                end
            end
            P_PRE: begin
                if (is_pre) begin
                    if (!a[10]) v = 2;
                    else if (g >= 1) begin
                        m_ph = P_REF; m_refs = 0;
                        m_lastref = 0; m_last = m_t;
                    end
                end else if (is_ref || is_mrs) v = 3;
                else if (!nop) v = 5;
            end
            P_REF: begin
                if (is_ref) begin
                    if (g < (m_lastref ? 2 : 1)) v = 4;
                    else begin
                        if (m_refs < 255) m_refs++;
                        m_lastref = 1; m_last = m_t;
                    end
                end else if (is_mrs) begin
                    if (m_refs < 2) v = 3;
                    else if (g < 2) v = 4;
                    else begin
                        m_mode = a;
                        b = bl_of(a[2:0]);
                        l = cl_of(a[6:4]);
                        if (b < 0 || l < 0) v = 7;
                        else begin
                            m_bl = b; m_cl = l;
                            m_ph = P_MRD; m_last = m_t;
                        end
                    end
                end else if (is_pre) v = 3;
                else if (!nop) v = 5;
            end
            P_MRD: begin
                if (!nop) v = 6;
                else if (g == 2) m_ph = P_RDY;
            end
            default: ;
        endcase
        if (v != 0) begin
            m_ph = P_ERR; m_code = v;
        end
    endtask

    task automatic cyc(input logic k, input logic [3:0] c,
                       input logic [12:0] a);
        cke = k; cmd = c; addr = a; ba = 2'($urandom);
        @(posedge iclk);
        model_step(k, c, a);
        #1;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b1, ($urandom_range(0, 1) != 0) ? C_DES : C_NOP,
                13'($urandom));
    endtask

    task automatic rst_slow();
        rst_s = 1'b1; cyc(1'b1, C_NOP, 13'd0); rst_s = 1'b0;
    endtask

    task automatic rst_fast();
        rst_f = 1'b1; cyc(1'b1, C_NOP, 13'd0); rst_f = 1'b0;
        model_reset();
    endtask

    task automatic fast_to_ref();
        rst_fast(); nops(FP); cyc(1'b1, C_PRE, 13'h400);
    endtask

    task automatic chk_slow_zero(input string tag);
        chk({tag, " done"}, s_done, 0);
        chk({tag, " err"}, s_err, 0);
        chk({tag, " code"}, s_code, 0);
        chk({tag, " mode"}, s_mode, 0);
        chk({tag, " bl"}, s_bl, 0);
        chk({tag, " cl"}, s_cl, 0);
        chk({tag, " refc"}, s_refc, 0);
    endtask

    task automatic legal_slow(input string tag);
        nops(10000);
        cyc(1'b1, C_PRE, 13'h400);
        repeat (8) begin
            cyc(1'b1, C_REF, 13'd0); cyc(1'b1, C_NOP, 13'd0);
        end
        cyc(1'b1, C_MRS, 13'h0023);
        cyc(1'b1, C_NOP, 13'd0);
        chk({tag, " done early"}, s_done, 0);
        cyc(1'b1, C_NOP, 13'd0);
        chk({tag, " done"}, s_done, 1);
        chk({tag, " err"}, s_err, 0);
        chk({tag, " mode"}, s_mode, 13'h0023);
        chk({tag, " bl"}, s_bl, 8);
        chk({tag, " cl"}, s_cl, 2);
        chk({tag, " refc"}, s_refc, 8);
    endtask

    task automatic chk_fast_model();
        chk("rnd done", f_done, (m_ph == P_RDY));
        chk("rnd err", f_err, (m_ph == P_ERR));
        chk("rnd code", f_code, m_code);
        chk("rnd mode", f_mode, m_mode);
        chk("rnd bl", f_bl, m_bl);
        chk("rnd cl", f_cl, m_cl);
        chk("rnd refc", f_refc, m_refs);
    endtask

    typedef struct {
        logic        k;
        logic [3:0]  c;
        logic [12:0] a;
        logic        done;
        logic        err;
        logic [7:0]  refc;
        logic [3:0]  bl;
        logic [1:0]  cl;
    } vec_t;

    vec_t tbl[18];

    initial begin
        logic [3:0]  rc;
        logic [12:0] ra;
        logic        rk;
        int          r;
        logic [12:0] good [4];
        good[0] = 13'h023; good[1] = 13'h032;
        good[2] = 13'h020; good[3] = 13'h037;
        model_reset();

        rst_s = 1'b1; rst_f = 1'b1;
        repeat (2) cyc(1'b1, C_NOP, 13'd0);
        rst_s = 1'b0;
        chk_slow_zero("reset");

        legal_slow("legal");

        rst_slow(); nops(5000); cyc(1'b1, C_REF, 13'd0);
        chk("early ref err", s_err, 1);
        chk("early ref code", s_code, 1);
        chk("early ref done", s_done, 0);

        rst_slow(); nops(4000);
        repeat (100) cyc(1'b0, C_REF, 13'd0);
        nops(6000); cyc(1'b1, C_PRE, 13'h400);
        chk("cke pall err", s_err, 0);
        cyc(1'b1, C_REF, 13'd0);
        chk("cke ref refc", s_refc, 1);
        chk("cke ref err", s_err, 0);

        rst_slow(); nops(10000); cyc(1'b1, C_PRE, 13'h400);
        cyc(1'b1, C_REF, 13'd0);
        chk("midref refc", s_refc, 1);
        rst_s = 1'b1; cyc(1'b1, C_REF, 13'd0); rst_s = 1'b0;
        chk_slow_zero("midreset");
        legal_slow("relegal");

        rst_s = 1'b1;

        for (int i = 0; i < 8; i++)
            tbl[i] = '{1'b1, C_NOP, 13'h0, 1'b0, 1'b0, 8'd0, 4'd0, 2'd0};
        tbl[8]  = '{1'b1, C_PRE, 13'h400, 1'b0, 1'b0, 8'd0, 4'd0, 2'd0};
        tbl[9]  = '{1'b1, C_REF, 13'h000, 1'b0, 1'b0, 8'd1, 4'd0, 2'd0};
        tbl[10] = '{1'b1, C_NOP, 13'h000, 1'b0, 1'b0, 8'd1, 4'd0, 2'd0};
        tbl[11] = '{1'b1, C_REF, 13'h000, 1'b0, 1'b0, 8'd2, 4'd0, 2'd0};
        tbl[12] = '{1'b0, C_REF, 13'h000, 1'b0, 1'b0, 8'd2, 4'd0, 2'd0};
        tbl[13] = '{1'b1, C_DES, 13'h1FF, 1'b0, 1'b0, 8'd2, 4'd0, 2'd0};
        tbl[14] = '{1'b1, C_MRS, 13'h032, 1'b0, 1'b0, 8'd2, 4'd4, 2'd3};
        tbl[15] = '{1'b1, C_NOP, 13'h000, 1'b0, 1'b0, 8'd2, 4'd4, 2'd3};
        tbl[16] = '{1'b1, C_NOP, 13'h000, 1'b1, 1'b0, 8'd2, 4'd4, 2'd3};
        tbl[17] = '{1'b1, C_ACT, 13'h000, 1'b1, 1'b0, 8'd2, 4'd4, 2'd3};
        rst_fast();
        for (int i = 0; i < 18; i++) begin
            cyc(tbl[i].k, tbl[i].c, tbl[i].a);
            chk($sformatf("tbl%0d done", i), f_done, tbl[i].done);
            chk($sformatf("tbl%0d err", i), f_err, tbl[i].err);
            chk($sformatf("tbl%0d refc", i), f_refc, tbl[i].refc);
            chk($sformatf("tbl%0d bl", i), f_bl, tbl[i].bl);
            chk($sformatf("tbl%0d cl", i), f_cl, tbl[i].cl);
        end

        rst_fast(); nops(FP - 1); cyc(1'b1, C_PRE, 13'h400);
        chk("short pwr code", f_code, 1);

        rst_fast(); nops(4); repeat (5) cyc(1'b0, C_NOP, 13'd0);
        nops(3); cyc(1'b1, C_PRE, 13'h400);
        chk("cke frozen code", f_code, 1);

        rst_fast(); nops(FP); cyc(1'b1, C_PRE, 13'h000);
        chk("pall a10 code", f_code, 2);

        rst_fast(); nops(FP); cyc(1'b1, C_REF, 13'h000);
        chk("pre ref code", f_code, 3);

        rst_fast(); nops(FP); cyc(1'b1, C_ACT, 13'h000);
        chk("pre ill code", f_code, 5);

        fast_to_ref(); cyc(1'b1, C_REF, 13'd0);
        cyc(1'b1, C_MRS, 13'h023);
        chk("mrs 1ref code", f_code, 3);

        fast_to_ref(); cyc(1'b1, C_REF, 13'd0); cyc(1'b1, C_REF, 13'd0);
        chk("ref ref err", f_err, 1);
        chk("ref ref code", f_code, 4);
        cyc(1'b1, C_ACT, 13'd0);
        chk("sticky code", f_code, 4);

        fast_to_ref();
        repeat (2) begin
            cyc(1'b1, C_REF, 13'd0); cyc(1'b1, C_NOP, 13'd0);
        end
        cyc(1'b1, C_MRS, 13'h024);
        chk("bad mode code", f_code, 7);
        chk("bad mode omode", f_mode, 13'h024);
        chk("bad mode done", f_done, 0);

        fast_to_ref();
        repeat (2) begin
            cyc(1'b1, C_REF, 13'd0); cyc(1'b1, C_NOP, 13'd0);
        end
        cyc(1'b1, C_MRS, 13'h023); cyc(1'b1, C_REF, 13'd0);
        chk("mrd cmd code", f_code, 6);

        for (int t = 0; t < 150; t++) begin
            rst_fast();
            chk_fast_model();
            for (int n = 0; n < $urandom_range(15, 50); n++) begin
                r  = $urandom_range(0, 99);
                rk = 1'b1; rc = C_NOP; ra = 13'($urandom);
                if (r < 10) begin
                    rk = 1'b0; rc = 4'($urandom);
                end else if (r < 55) begin
                    rc = ($urandom_range(0, 1) != 0) ? C_DES : C_NOP;
                end else if (r < 92) begin
                    case (m_ph)
                        P_PRE: begin
                            rc = C_PRE;
                            if ($urandom_range(0, 7) != 0) ra[10] = 1'b1;
                        end
                        P_REF: begin
                            if (m_refs < 2 || $urandom_range(0, 2) == 0)
                                rc = C_REF;
                            else begin
                                rc = C_MRS;
                                if ($urandom_range(0, 4) != 0)
                                    ra = good[$urandom_range(0, 3)];
                            end
                        end
                        default: rc = C_NOP;
                    endcase
                end else begin
                    rc = 4'($urandom);
                end
                cyc(rk, rc, ra);
                chk_fast_model();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_init_checker.md
# sdram_init_checker

Passive responder for the SDRAM power-up protocol: it sits on the same SDRAM command bus driven by the initialization sequencer and decodes every command the sequencer issues. It checks ordering and minimum spacing of the JEDEC power-up sequence: power-up NOPs, PRECHARGE ALL, AUTO REFRESH ×N, then LOAD MODE. It latches the mode register word, reports ready when the device may accept normal traffic, and flags the first protocol violation with a sticky error code. It is used on the board bench and in simulation next to the controller.

## Interface
- T_PWR, 10000, NOP/deselect cycles required before the first command
- MIN_REFRESH, 2, AUTO REFRESH commands required before LOAD MODE
- T_RP, 1, min cycles PRECHARGE → next command
- T_RFC, 2, min cycles REFRESH → next command
- T_MRD, 2, min cycles LOAD MODE → ready
- iclk  in  1  system clock; bus sampled on rising edge
- ireset  in  1  synchronous, active-high reset
- DRAM_CKE  in  1  clock enable
- DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N  in  1 each  command strobes
- DRAM_ADDR  in  13  address (A10 = all-banks flag)
- DRAM_BA  in  2  bank select
- odone  out  1  init sequence complete and legal
- oerr  out  1  sticky protocol violation
- oerr_code  out  3  first violation code
- omode  out  13  latched LOAD MODE address word
- oburst_len  out  4  decoded burst length (1/2/4/8; 0 = full page)
- ocas_lat  out  2  decoded CAS latency (2 or 3)
- oref_count  out  8  refreshes counted, saturating at 255

## Operation
- Command decode of {CS_N,RAS_N,CAS_N,WE_N}: 1xxx deselect (treated as NOP), 0111 NOP, 0010 PRECHARGE, 0001 REFRESH, 0000 LOAD MODE. Any other code is illegal before ready.
- Cycles with DRAM_CKE=0 are ignored: no counter advances and no check is made.
- `gap` counter: cleared when a command is accepted, +1 on every other sampled cycle, saturating at 255.
- States and transitions:
  - **PWR**: NOP increments pwr_cnt (16-bit, saturating). When pwr_cnt ≥ T_PWR → **PRE**. Any non-NOP command before that → err 1.
  - **PRE**: NOP stays. PRECHARGE with A10=1 and gap ≥ 1 → **REF**, ref_cnt=0. PRECHARGE with A10=0 → err 2. REFRESH or LOAD MODE → err 3. Illegal command → err 5.
  - **REF**: REFRESH needs gap ≥ T_RP after PRECHARGE and gap ≥ T_RFC after REFRESH, else err 4; on success ref_cnt+1.
    - LOAD MODE with ref_cnt ≥ MIN_REFRESH and gap ≥ T_RFC → latch omode and go to **MRD**.
    - LOAD MODE with ref_cnt < MIN_REFRESH → err 3. LOAD MODE with gap < T_RFC → err 4.
    - PRECHARGE → err 3. Illegal command → err 5.
  - **MRD**: any non-NOP command → err 6. When gap = T_MRD → **RDY**.
  - **RDY**: odone=1. The bus is no longer checked; state holds until reset.
  - **ERR**: oerr=1; oerr_code frozen; state holds until reset.
- LOAD MODE decode:
  - A[2:0]: 000→1, 001→2, 010→4, 011→8, 111→0. Any other value → err 7.
  - A[6:4]: 010→2, 011→3. Any other value → err 7.
  - On err 7, omode is still latched.
- If one cycle matches several violations, the lowest code wins.

## Timing
- Reset values: odone=0, oerr=0, oerr_code=0, omode=0, oburst_len=0, ocas_lat=0, oref_count=0; state PWR; all counters 0.
- Outputs are registered. A command sampled on edge n is reflected on outputs after edge n; a violation on edge n gives oerr=1 after edge n.
- odone rises on the edge where gap reaches T_MRD, i.e. the T_MRD-th sampled edge after LOAD MODE.
- Reset mid-sequence clears everything at once; checking restarts in PWR.

## Test plan
- Legal sequence (10000 NOP, PALL A=0x400, 8× REF/NOP, MRS A=0x0023, NOP, NOP) → odone=1 two edges after MRS, omode=0x0023, oburst_len=8, ocas_lat=2, oref_count=8, oerr=0.
- REF after 5000 NOPs → oerr=1, oerr_code=1 after that edge; odone stays 0.
- PALL with A=0x000 → code 2. MRS after only 1 REF → code 3.
- Back-to-back REF,REF → code 4. NOP then MRS A=0x0024 → code 7, omode=0x0024.
- CKE=0 for 100 cycles inside the NOP window → pwr_cnt frozen; PALL at 10000 counted NOPs accepted.
- ireset asserted in REF state → all outputs 0 next edge; full legal sequence then passes.
